// File: rtl/seq_mult_ovf_if.sv
// seq_mult_ovf_if: request/response bundle between the execute stage and the Booth multiplier
interface seq_mult_ovf_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             ovf;
  modport master (output start, a, b, input busy, done, result, result_hi, ovf);
  modport slave (input start, a, b, output busy, done, result, result_hi, ovf);
endinterface

// File: rtl/seq_mult_ovf.sv
// seq_mult_ovf: multicycle radix-2 Booth signed multiplier with overflow flag and optional saturation
module seq_mult_ovf #(
  parameter int WIDTH    = 32,
  parameter bit SATURATE = 1'b0
) (
  input logic          clock,
  input logic          reset_n,
  seq_mult_ovf_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state, nxt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   prod;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     upper, addend, sum;
  logic               ovf_w;
  logic [WIDTH-1:0]   sat_w;
  assign upper  = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
  assign addend = {mcand[WIDTH-1], mcand};
  assign sum    = prod[1:0] == 2'b01 ? upper + addend : prod[1:0] == 2'b10 ? upper - addend : upper;
  assign ovf_w  = !(&prod[2*WIDTH:WIDTH] || ~|prod[2*WIDTH:WIDTH]);
  assign sat_w  = prod[2*WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign bus.busy = state != IDLE;
  // state register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  end
  // next state: accept in IDLE, WIDTH Booth steps in RUN, one result cycle in DONE
  always_comb begin
    nxt = state == IDLE ? (bus.start ? RUN : IDLE)
        : state == RUN  ? (cnt == CW'(WIDTH - 1) ? DONE : RUN)
        : IDLE;
  end
  // operand capture, Booth add/subtract plus arithmetic shift, result registration
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mcand         <= '0;
      prod          <= '0;
      cnt           <= '0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.result_hi <= '0;
      bus.ovf       <= 1'b0;
    end else begin
      bus.done <= state == DONE;
      if (state == IDLE && bus.start) begin
        mcand <= bus.a;
        prod  <= {{WIDTH{1'b0}}, bus.b, 1'b0};
        cnt   <= '0;
      end
      if (state == RUN) begin
        prod <= {sum, prod[WIDTH:1]};
        cnt  <= cnt + 1'b1;
      end
      if (state == DONE) begin
        bus.result    <= SATURATE && ovf_w ? sat_w : prod[WIDTH:1];
        bus.result_hi <= prod[2*WIDTH:WIDTH+1];
        bus.ovf       <= ovf_w;
      end
    end
  end
endmodule

// File: tb/tb_seq_mult_ovf.sv
// tb_seq_mult_ovf: scoreboard bench for the Booth multiplier at WIDTH=32 (plain and saturating) and WIDTH=8
module tb_seq_mult_ovf;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;
  seq_mult_ovf_if #(.WIDTH(32)) b0 ();
  seq_mult_ovf_if #(.WIDTH(32)) b1 ();
  seq_mult_ovf_if #(.WIDTH(8))  b8 ();
  assign b1.start = b0.start;
  assign b1.a     = b0.a;
  assign b1.b     = b0.b;
  seq_mult_ovf #(.WIDTH(32), .SATURATE(1'b0)) d0 (.clock(clock), .reset_n(reset_n), .bus(b0.slave));
  seq_mult_ovf #(.WIDTH(32), .SATURATE(1'b1)) d1 (.clock(clock), .reset_n(reset_n), .bus(b1.slave));
  seq_mult_ovf #(.WIDTH(8),  .SATURATE(1'b0)) d8 (.clock(clock), .reset_n(reset_n), .bus(b8.slave));
  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        ovf;
  } exp_t;
  exp_t q0[$], q1[$], q8[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ndone0 = 0;
  int last_done0 = 0;
  int prev_done0 = 0;
  always @(posedge clock) cyc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // scoreboard monitors: pop the oldest expectation whenever a DUT pulses done
  always @(negedge clock) begin
    exp_t e;
    if (b0.done) begin
      prev_done0 = last_done0;
      last_done0 = cyc;
      ndone0++;
      if (q0.size() == 0) chk("done0_unexpected", 1, 0);
      else begin
        e = q0.pop_front();
        chk("res32", b0.result, e.res);
        chk("hi32", b0.result_hi, e.hi);
        chk("ovf32", b0.ovf, e.ovf);
      end
    end
  end
  always @(negedge clock) begin
    exp_t e;
    if (b1.done) begin
      if (q1.size() == 0) chk("done_sat_unexpected", 1, 0);
      else begin
        e = q1.pop_front();
        chk("res_sat", b1.result, e.res);
        chk("hi_sat", b1.result_hi, e.hi);
        chk("ovf_sat", b1.ovf, e.ovf);
      end
    end
  end
  always @(negedge clock) begin
    exp_t e;
    if (b8.done) begin
      if (q8.size() == 0) chk("done8_unexpected", 1, 0);
      else begin
        e = q8.pop_front();
        chk("res8", b8.result, e.res);
        chk("hi8", b8.result_hi, e.hi);
        chk("ovf8", b8.ovf, e.ovf);
      end
    end
  end
  task automatic push32(input logic [31:0] res, hi, input logic ovf);
    q0.push_back('{res, hi, ovf});
    q1.push_back('{ovf ? (hi[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : res, hi, ovf});
  endtask
  task automatic op32(input logic [31:0] a, b, res, hi, input logic ovf);
    int n;
    push32(res, hi, ovf);
    @(posedge clock); #1;
    b0.start = 1'b1; b0.a = a; b0.b = b;
    @(posedge clock); #1;
    b0.start = 1'b0;
    n = 0;
    while (!b0.done && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("latency32", n, 33);
  endtask
  task automatic op8(input logic [7:0] a, b, res, hi, input logic ovf);
    int n;
    q8.push_back('{{24'h0, res}, {24'h0, hi}, ovf});
    @(posedge clock); #1;
    b8.start = 1'b1; b8.a = a; b8.b = b;
    @(posedge clock); #1;
    b8.start = 1'b0;
    n = 0;
    while (!b8.done && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("latency8", n, 9);
  endtask
  task automatic rnd32;
    logic [31:0] a, b;
    logic [63:0] pv;
    longint p;
    a = $urandom; b = $urandom;
    p = longint'($signed(a)) * longint'($signed(b));
    pv = p;
    op32(a, b, pv[31:0], pv[63:32], !(pv[63:31] == '0 || pv[63:31] == '1));
  endtask
  task automatic rnd8;
    logic [7:0] a, b;
    logic [31:0] pv;
    int p;
    a = 8'($urandom); b = 8'($urandom);
    p = int'($signed(a)) * int'($signed(b));
    pv = p;
    op8(a, b, pv[7:0], pv[15:8], !(pv[15:7] == '0 || pv[15:7] == '1));
  endtask
  initial begin
    int n0;
    reset_n = 1'b0;
    b0.start = 1'b1; b0.a = 32'd7; b0.b = 32'd9;
    b8.start = 1'b1; b8.a = 8'd7;  b8.b = 8'd9;
    repeat (3) @(posedge clock);
    #1;
    b0.start = 1'b0; b8.start = 1'b0;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_busy", b0.busy, 0);
    chk("rst_done", b0.done, 0);
    chk("rst_result", b0.result, 0);
    chk("rst_result_hi", b0.result_hi, 0);
    chk("rst_ovf", b0.ovf, 0);
    chk("rst_busy8", b8.busy, 0);
    op32(32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0);
    op32(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b1);
    op32(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1);
    op32(32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    op32(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    op32(32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 32'hFFFF_FFFF, 1'b0);
    op32(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001, 32'h3FFF_FFFF, 1'b1);
    op32(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 1'b1);
    op32(32'h0001_2345, 32'hFFFF_0000, 32'hDCBB_0000, 32'hFFFF_FFFE, 1'b1);
    op32(32'd46341, 32'd46341, 32'h8000_1219, 32'h0000_0000, 1'b1);
    op32(32'd46340, 32'd46340, 32'h7FFE_A810, 32'h0000_0000, 1'b0);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0);
    op8(8'h80, 8'hFF, 8'h80, 8'h00, 1'b1);
    op8(8'h80, 8'h01, 8'h80, 8'hFF, 1'b0);
    op8(8'h0B, 8'h0B, 8'h79, 8'h00, 1'b0);
    op8(8'h0C, 8'h0B, 8'h84, 8'h00, 1'b1);
    op8(8'hF6, 8'h0D, 8'h7E, 8'hFF, 1'b1);
    op8(8'h7F, 8'h7F, 8'h01, 8'h3F, 1'b1);
    for (int i = 0; i < 6; i++) rnd32();
    for (int i = 0; i < 12; i++) rnd8();
    push32(32'hFFFF_FFFE, 32'h0000_0000, 1'b1);
    push32(32'hFFFF_FFD6, 32'hFFFF_FFFF, 1'b0);
    n0 = ndone0;
    @(posedge clock); #1;
    b0.start = 1'b1; b0.a = 32'h7FFF_FFFF; b0.b = 32'd2;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (i == 10) begin
        b0.a = 32'hFFFF_FFF9; b0.b = 32'd6;
      end
    end
    b0.start = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    chk("held_start_pulses", ndone0 - n0, 2);
    chk("held_start_spacing", last_done0 - prev_done0, 34);
    @(posedge clock); #1;
    b0.start = 1'b1; b0.a = 32'd5; b0.b = 32'd5;
    @(posedge clock); #1;
    b0.start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk("abort_busy", b0.busy, 0);
    chk("abort_done", b0.done, 0);
    chk("abort_result", b0.result, 0);
    chk("abort_result_hi", b0.result_hi, 0);
    chk("abort_ovf", b0.ovf, 0);
    n0 = ndone0;
    repeat (40) @(posedge clock);
    #1;
    chk("abort_no_done", ndone0 - n0, 0);
    op32(32'd3, 32'hFFFF_FFFB, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("q32_drained", q0.size(), 0);
    chk("qsat_drained", q1.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
